// File: rtl/wallace_mult_pkg.sv
// rtl/wallace_mult_pkg.sv - shared constants, stage-2 payload type and reduction-tree sizing helpers
package wallace_mult_pkg;

    localparam int WMP_STAGES = 3;
    // Widest product for the supported operand range; narrower builds zero-fill the top.
    localparam int WMP_ROW_W  = 64;

    typedef struct packed {
        logic [WMP_ROW_W-1:0] sum;
        logic [WMP_ROW_W-1:0] carry;
        logic                 valid;
    } wmp_s2_t;

    // Rows entering the tree: WIDTH+1 Baugh-Wooley rows plus one constant-correction row.
    function automatic int wmp_rows_at(input int width, input int level);
        int r;
        r = width + 2;
        for (int l = 0; l < level; l++) begin
            r = 2 * (r / 3) + (r % 3);
        end
        return r;
    endfunction

    function automatic int wmp_tree_depth(input int width);
        int r;
        int d;
        r = width + 2;
        d = 0;
        while (r > 2) begin
            r = 2 * (r / 3) + (r % 3);
            d++;
        end
        return d;
    endfunction

endpackage

// File: rtl/wallace_csa_3to2.sv
// rtl/wallace_csa_3to2.sv - bit-vector 3:2 carry-save compressor
module wallace_csa_3to2 #(
    parameter int W = 16
) (
    input  logic [W-1:0] x0,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] x2,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    assign sum   = x0 ^ x1 ^ x2;
    // Carry weighs one position up; the bit shifted out lies beyond the product width.
    assign carry = ((x0 & x1) | (x0 & x2) | (x1 & x2)) << 1;

endmodule

// File: rtl/wallace_mult_pipe.sv
// rtl/wallace_mult_pipe.sv - 3-stage Baugh-Wooley/Wallace multiplier; WALLACE_MULT_ACC_EN adds an accumulator
module wallace_mult_pipe
    import wallace_mult_pkg::*;
#(
    parameter  int WIDTH  = 8,
    localparam int PROD_W = 2 * WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              a_signed,
    input  logic              b_signed,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] z
`ifdef WALLACE_MULT_ACC_EN
    ,
    input  logic              acc_en,
    output logic [PROD_W+7:0] acc_out
`endif
);

    localparam int N     = WIDTH + 1;
    localparam int ROWS  = WIDTH + 2;
    localparam int DEPTH = wmp_tree_depth(WIDTH);

    logic                  adv;
    logic                  v1;
    logic                  v3;
    logic [WMP_STAGES-1:0] vld;
    logic [N-1:0]          ax;
    logic [N-1:0]          bx;
    logic [PROD_W-1:0]     pp_d [ROWS];
    logic [PROD_W-1:0]     pp_q [ROWS];
    logic [PROD_W-1:0]     lvl  [DEPTH+1][ROWS];
    wmp_s2_t               s2_q;

    assign vld       = {v3, s2_q.valid, v1};
    assign out_valid = vld[WMP_STAGES-1];
    assign adv       = out_ready || !out_valid;
    assign in_ready  = adv;

    assign ax = {a_signed & a[WIDTH-1], a};
    assign bx = {b_signed & b[WIDTH-1], b};

    // Signed (WIDTH+1)x(WIDTH+1) Baugh-Wooley: sign-row/column terms inverted, +2^N correction.
    // The 2^(2N-1) correction and the top sign product lie above PROD_W and drop out.
    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            pp_d[i] = '0;
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (i + j < PROD_W) begin
                    pp_d[i][i+j] = (ax[j] & bx[i]) ^ ((i == N - 1) != (j == N - 1));
                end
            end
        end
        pp_d[N][N] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (adv && in_valid) begin
            pp_q <= pp_d;
        end
    end

    for (genvar k = 0; k < ROWS; k++) begin : g_lvl0
        assign lvl[0][k] = pp_q[k];
    end

    for (genvar l = 0; l < DEPTH; l++) begin : g_lvl
        localparam int R  = wmp_rows_at(WIDTH, l);
        localparam int G  = R / 3;
        localparam int RN = wmp_rows_at(WIDTH, l + 1);
        for (genvar g = 0; g < G; g++) begin : g_csa
            wallace_csa_3to2 #(.W(PROD_W)) u_csa (
                .x0   (lvl[l][3*g]),
                .x1   (lvl[l][3*g+1]),
                .x2   (lvl[l][3*g+2]),
                .sum  (lvl[l+1][2*g]),
                .carry(lvl[l+1][2*g+1])
            );
        end
        for (genvar k = 0; k < R % 3; k++) begin : g_pass
            assign lvl[l+1][2*G+k] = lvl[l][3*G+k];
        end
        for (genvar k = RN; k < ROWS; k++) begin : g_zero
            assign lvl[l+1][k] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1   <= 1'b0;
            s2_q <= '0;
            v3   <= 1'b0;
            z    <= '0;
        end else if (adv) begin
            v1         <= in_valid;
            s2_q.valid <= v1;
            if (v1) begin
                s2_q.sum   <= WMP_ROW_W'(lvl[DEPTH][0]);
                s2_q.carry <= WMP_ROW_W'(lvl[DEPTH][1]);
            end
            v3 <= s2_q.valid;
            if (s2_q.valid) begin
                z <= s2_q.sum[PROD_W-1:0] + s2_q.carry[PROD_W-1:0];
            end
        end
    end

    if (PROD_W < WMP_ROW_W) begin : g_unused
        logic unused_hi;
        assign unused_hi = ^{s2_q.sum[WMP_ROW_W-1:PROD_W], s2_q.carry[WMP_ROW_W-1:PROD_W]};
    end

`ifdef WALLACE_MULT_ACC_EN
    localparam int ACC_W = PROD_W + 8;

    logic [WMP_STAGES-1:0] sg_p;
    logic [WMP_STAGES-1:0] en_p;
    logic [ACC_W-1:0]      acc_q;
    logic [ACC_W-1:0]      z_ext;

    // Sidebands shift in lockstep with the stage valid bits.
    always_ff @(posedge clk) begin
        if (adv) begin
            sg_p <= {sg_p[WMP_STAGES-2:0], a_signed | b_signed};
            en_p <= {en_p[WMP_STAGES-2:0], acc_en};
        end
    end

    assign z_ext   = sg_p[WMP_STAGES-1] ? {{8{z[PROD_W-1]}}, z} : {8'h00, z};
    assign acc_out = en_p[WMP_STAGES-1] ? acc_q + z_ext : z_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (out_valid && out_ready) begin
            acc_q <= acc_out;
        end
    end
`endif

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// tb/tb_wallace_mult_pipe.sv - scoreboard bench for wallace_mult_pipe at WIDTH 4 and 8
module tb_wallace_mult_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic       v4, r4, as4, bs4, ov4, or4;
    logic [3:0] a4, b4;
    logic [7:0] z4;

    logic        v8, r8, as8, bs8, ov8, or8;
    logic [7:0]  a8, b8;
    logic [15:0] z8;

    logic [7:0]  q4 [$];
    logic [15:0] q8 [$];
    int          del8;
    int          n, n2, d0;
    logic [15:0] zh;

`ifdef WALLACE_MULT_ACC_EN
    logic        en4, en8;
    logic [15:0] acc4;
    logic [23:0] acc8;
    logic [23:0] acc_model;
    logic [23:0] qa [$];
    logic [7:0]  t6a [4] = '{8'd10, 8'd20, 8'd30, 8'd5};
    logic        t6e [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [23:0] t6x [4] = '{24'd10, 24'd30, 24'd60, 24'd5};
`endif

    wallace_mult_pipe #(.WIDTH(4)) u_d4 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (v4),
        .in_ready (r4),
        .a        (a4),
        .b        (b4),
        .a_signed (as4),
        .b_signed (bs4),
        .out_valid(ov4),
        .out_ready(or4),
        .z        (z4)
`ifdef WALLACE_MULT_ACC_EN
        ,
        .acc_en   (en4),
        .acc_out  (acc4)
`endif
    );

    wallace_mult_pipe #(.WIDTH(8)) u_d8 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (v8),
        .in_ready (r8),
        .a        (a8),
        .b        (b8),
        .a_signed (as8),
        .b_signed (bs8),
        .out_valid(ov8),
        .out_ready(or8),
        .z        (z8)
`ifdef WALLACE_MULT_ACC_EN
        ,
        .acc_en   (en8),
        .acc_out  (acc8)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m4(input logic [3:0] x, input logic [3:0] y,
                                      input logic sx, input logic sy);
        logic signed [4:0] xa, xb;
        logic signed [9:0] p;
        xa = {sx & x[3], x};
        xb = {sy & y[3], y};
        p  = xa * xb;
        return p[7:0];
    endfunction

    function automatic logic [15:0] m8(input logic [7:0] x, input logic [7:0] y,
                                       input logic sx, input logic sy);
        logic signed [8:0]  xa, xb;
        logic signed [17:0] p;
        xa = {sx & x[7], x};
        xb = {sy & y[7], y};
        p  = xa * xb;
        return p[15:0];
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (ov4 && or4) begin
                check("d4_queue_nonempty", 64'(q4.size() != 0), 64'd1);
                if (q4.size() != 0) check("d4_z", 64'(z4), 64'(q4.pop_front()));
            end
            if (v4 && r4) q4.push_back(m4(a4, b4, as4, bs4));
        end
    end

    always @(negedge clk) begin
        logic [15:0] p;
        if (!rst) begin
            if (ov8 && or8) begin
                del8++;
                check("d8_queue_nonempty", 64'(q8.size() != 0), 64'd1);
                if (q8.size() != 0) check("d8_z", 64'(z8), 64'(q8.pop_front()));
`ifdef WALLACE_MULT_ACC_EN
                if (qa.size() != 0) check("d8_acc", 64'(acc8), 64'(qa.pop_front()));
`endif
            end
            if (v8 && r8) begin
                p = m8(a8, b8, as8, bs8);
                q8.push_back(p);
`ifdef WALLACE_MULT_ACC_EN
                acc_model = (en8 ? acc_model : 24'd0) +
                            ((as8 | bs8) ? {{8{p[15]}}, p} : {8'h00, p});
                qa.push_back(acc_model);
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ov4(input string tag);
        int k;
        k = 0;
        while (!ov4 && k < 20) begin
            tick();
            k++;
        end
        check(tag, 64'(ov4), 64'd1);
    endtask

    task automatic wait_ov8(input string tag);
        int k;
        k = 0;
        while (!ov8 && k < 20) begin
            tick();
            k++;
        end
        check(tag, 64'(ov8), 64'd1);
    endtask

    initial begin
        rst = 1'b1;
        v4 = 1'b0; a4 = '0; b4 = '0; as4 = 1'b0; bs4 = 1'b0; or4 = 1'b1;
        v8 = 1'b0; a8 = '0; b8 = '0; as8 = 1'b0; bs8 = 1'b0; or8 = 1'b1;
        del8 = 0;
`ifdef WALLACE_MULT_ACC_EN
        en4 = 1'b0; en8 = 1'b0; acc_model = '0;
`endif
        tick();
        tick();
        check("rst_ov4", 64'(ov4), 64'd0);
        check("rst_z4", 64'(z4), 64'd0);
        check("rst_ov8", 64'(ov8), 64'd0);
        check("rst_z8", 64'(z8), 64'd0);
        or4 = 1'b0;
        or8 = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_in_ready4", 64'(r4), 64'd1);
        check("rst_in_ready8", 64'(r8), 64'd1);
        or4 = 1'b1;
        or8 = 1'b1;

        // Single pulse, unsigned 15*15, latency of exactly three cycles
        a4 = 4'hF; b4 = 4'hF; v4 = 1'b1;
        tick();
        v4 = 1'b0;
        check("t1_lat_c1", 64'(ov4), 64'd0);
        tick();
        check("t1_lat_c2", 64'(ov4), 64'd0);
        tick();
        check("t1_ov", 64'(ov4), 64'd1);
        check("t1_z", 64'(z4), 64'hE1);
        tick();
        check("t1_ov_drop", 64'(ov4), 64'd0);

        // Signed x unsigned, then signed x signed at the most negative value
        a4 = 4'hD; b4 = 4'h5; as4 = 1'b1; bs4 = 1'b0; v4 = 1'b1;
        tick();
        a4 = 4'h8; b4 = 4'h8; as4 = 1'b1; bs4 = 1'b1;
        tick();
        v4 = 1'b0;
        wait_ov4("t2_wait");
        check("t2_z_sxu", 64'(z4), 64'hF1);
        tick();
        check("t2_ov2", 64'(ov4), 64'd1);
        check("t2_z_sxs", 64'(z4), 64'h40);
        tick();

        // Mixed-signedness streams on both widths
        for (int i = 0; i < 24; i++) begin
            a4 = 4'($urandom); b4 = 4'($urandom);
            as4 = 1'($urandom_range(0, 1)); bs4 = 1'($urandom_range(0, 1)); v4 = 1'b1;
            a8 = 8'($urandom); b8 = 8'($urandom);
            as8 = 1'($urandom_range(0, 1)); bs8 = 1'($urandom_range(0, 1)); v8 = 1'b1;
`ifdef WALLACE_MULT_ACC_EN
            en8 = 1'($urandom_range(0, 1));
`endif
            tick();
        end
        v4 = 1'b0;
        v8 = 1'b0;
        repeat (6) tick();
        check("mix_d4_drained", 64'(q4.size()), 64'd0);
        check("mix_d8_drained", 64'(q8.size()), 64'd0);

        // Back-to-back stream a=1..20, b=3: results on 20 consecutive cycles
        as8 = 1'b0; bs8 = 1'b0; b8 = 8'd3;
`ifdef WALLACE_MULT_ACC_EN
        en8 = 1'b0;
`endif
        for (int c = 0; c < 23; c++) begin
            if (c < 20) begin
                v8 = 1'b1;
                a8 = 8'(c + 1);
            end else begin
                v8 = 1'b0;
            end
            tick();
            if (c >= 2 && c <= 21) begin
                check("t3_ov", 64'(ov8), 64'd1);
                check("t3_z", 64'(z8), 64'(3 * (c - 1)));
            end
        end
        check("t3_ov_end", 64'(ov8), 64'd0);

        // Six transactions with a five-cycle stall after the first result
        d0 = del8;
        b8 = 8'd7;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    v8 = 1'b1;
                    a8 = 8'(10 + i);
                    n = 0;
                    while (!r8 && n < 40) begin
                        @(posedge clk);
                        #2;
                        n++;
                    end
                    @(posedge clk);
                    #2;
                end
                v8 = 1'b0;
            end
            begin
                n2 = 0;
                while (!ov8 && n2 < 40) begin
                    @(posedge clk);
                    #1;
                    n2++;
                end
                check("t4_first", 64'(ov8), 64'd1);
                @(posedge clk);
                #1;
                or8 = 1'b0;
                zh = z8;
                for (int k = 0; k < 5; k++) begin
                    @(posedge clk);
                    #1;
                    check("t4_stall_ov", 64'(ov8), 64'd1);
                    check("t4_stall_z", 64'(z8), 64'(zh));
                    check("t4_stall_rdy", 64'(r8), 64'd0);
                end
                or8 = 1'b1;
            end
        join
        n = 0;
        while (q8.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        tick();
        check("t4_drained", 64'(q8.size()), 64'd0);
        check("t4_count", 64'(del8 - d0), 64'd6);

        // Reset with two transactions in flight
        a8 = 8'd9; b8 = 8'd9; v8 = 1'b1;
        tick();
        a8 = 8'd11;
        tick();
        v8 = 1'b0;
        rst = 1'b1;
        q4.delete();
        q8.delete();
`ifdef WALLACE_MULT_ACC_EN
        qa.delete();
        acc_model = '0;
`endif
        tick();
        check("t5_ov", 64'(ov8), 64'd0);
        check("t5_z", 64'(z8), 64'd0);
        rst = 1'b0;
        check("t5_rdy", 64'(r8), 64'd1);
        a8 = 8'd6; b8 = 8'd7; v8 = 1'b1;
        tick();
        v8 = 1'b0;
        check("t5_no_stale1", 64'(ov8), 64'd0);
        tick();
        check("t5_no_stale2", 64'(ov8), 64'd0);
        tick();
        check("t5_ov_new", 64'(ov8), 64'd1);
        check("t5_z_new", 64'(z8), 64'd42);
        tick();
        check("t5_ov_drop", 64'(ov8), 64'd0);

`ifdef WALLACE_MULT_ACC_EN
        // Accumulate 10, 20, 30 then restart with 5
        as8 = 1'b0; bs8 = 1'b0; b8 = 8'd1;
        for (int i = 0; i < 4; i++) begin
            a8 = t6a[i];
            en8 = t6e[i];
            v8 = 1'b1;
            tick();
            v8 = 1'b0;
            wait_ov8("t6_wait");
            check("t6_acc", 64'(acc8), 64'(t6x[i]));
            tick();
        end
`endif

        repeat (4) tick();
        check("end_d8_drained", 64'(q8.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
